// File: rtl/intc_pkg.sv
// Shared types and helpers for the interrupt enable/arbitration controller.
package intc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_EDGE_MASK = 32'hFFFF_FFFF;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// Lowest-index-first priority encoder; channel 0 has the highest priority.
module intc_prio_enc
  import intc_pkg::*;
#(
  parameter int N_CH = 8,
  parameter int ID_W = id_width(N_CH)
) (
  input  logic [N_CH-1:0] req,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  // Scan downwards so the lowest set index is the last one written.
  always_comb begin
    idx = '0;
    any = |req;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req[i]) idx = ID_W'(i);
    end
  end

endmodule

// File: rtl/intc_enable_ctrl.sv
// N-channel interrupt pending/enable controller with fixed-priority
// arbitration and an irq/ack/eoi handshake towards the CPU.
module intc_enable_ctrl
  import intc_pkg::*;
#(
  parameter int              N_CH      = 8,
  parameter int              ID_W      = id_width(N_CH),
  parameter logic [N_CH-1:0] EDGE_MASK = DEFAULT_EDGE_MASK[N_CH-1:0]
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] irq_in,
  input  logic            pie_wr,
  input  logic [N_CH-1:0] pie_wdata,
  output logic [N_CH-1:0] pie,
  input  logic            gie_set,
  input  logic            gie_clr,
  output logic            gie,
  output logic [N_CH-1:0] pending,
  output logic            irq,
  input  logic            ack,
  output logic [ID_W-1:0] vector,
  output logic            in_service,
  input  logic            eoi
);

  state_t          state;
  logic [N_CH-1:0] irq_q;
  logic            gie_restore;

  logic [N_CH-1:0] set_vec;
  logic [N_CH-1:0] req_vec;
  logic [N_CH-1:0] pie_eff;
  logic [N_CH-1:0] clr_onehot;
  logic [ID_W-1:0] win_idx;
  logic            win_any;
  logic            accept;
  logic            gie_nxt;

  assign set_vec = (irq_in & ~irq_q & EDGE_MASK) | (irq_in & ~EDGE_MASK);
  assign req_vec = pending & pie;
  assign pie_eff = pie_wr ? pie_wdata : pie;

  intc_prio_enc #(
    .N_CH (N_CH),
    .ID_W (ID_W)
  ) u_prio_enc (
    .req (req_vec),
    .idx (win_idx),
    .any (win_any)
  );

  assign accept     = (state == REQ) && ack && win_any;
  assign clr_onehot = accept ? ({{(N_CH-1){1'b0}}, 1'b1} << win_idx) : '0;

  // Later assignments override earlier ones: handshake effects beat the
  // software set/clear requests, and an empty enable mask always forces 0.
  always_comb begin
    gie_nxt = gie;
    if (gie_clr) begin
      gie_nxt = 1'b0;
    end else if (gie_set && (state != SERVICE) && (|pie_eff)) begin
      gie_nxt = 1'b1;
    end
    if (!(|pie_eff)) gie_nxt = 1'b0;
    if (accept) gie_nxt = 1'b0;
    if ((state == SERVICE) && eoi) gie_nxt = gie_restore && !gie_clr && (|pie_eff);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pie         <= '0;
      gie         <= 1'b0;
      pending     <= '0;
      irq         <= 1'b0;
      vector      <= '0;
      in_service  <= 1'b0;
      irq_q       <= '0;
      gie_restore <= 1'b0;
      state       <= IDLE;
    end else begin
      irq_q   <= irq_in;
      pending <= (pending & ~clr_onehot) | set_vec;
      gie     <= gie_nxt;
      if (pie_wr) pie <= pie_wdata;

      case (state)
        IDLE: begin
          if (gie && win_any) begin
            irq   <= 1'b1;
            state <= REQ;
          end
        end
        REQ: begin
          if (accept) begin
            vector      <= win_idx;
            gie_restore <= ~gie_clr;
            in_service  <= 1'b1;
            irq         <= 1'b0;
            state       <= SERVICE;
          end else if (!gie || !win_any) begin
            irq   <= 1'b0;
            state <= IDLE;
          end
        end
        SERVICE: begin
          if (gie_clr) gie_restore <= 1'b0;
          if (eoi) begin
            in_service <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_intc_enable_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic, all compared
// cycle by cycle against a channel-array reference model.
module tb_intc_enable_ctrl;

  localparam int N = 8;
  localparam logic [N-1:0] EM = 8'hEF;  // channel 4 is level-triggered

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] irq_in;
  logic         pie_wr;
  logic [N-1:0] pie_wdata;
  logic [N-1:0] pie;
  logic         gie_set;
  logic         gie_clr;
  logic         gie;
  logic [N-1:0] pending;
  logic         irq;
  logic         ack;
  logic [2:0]   vector;
  logic         in_service;
  logic         eoi;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  intc_enable_ctrl #(
    .N_CH      (N),
    .EDGE_MASK (EM)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq_in     (irq_in),
    .pie_wr     (pie_wr),
    .pie_wdata  (pie_wdata),
    .pie        (pie),
    .gie_set    (gie_set),
    .gie_clr    (gie_clr),
    .gie        (gie),
    .pending    (pending),
    .irq        (irq),
    .ack        (ack),
    .vector     (vector),
    .in_service (in_service),
    .eoi        (eoi)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: one entry per channel, handshake phase as a small int
  // (0 = waiting, 1 = requesting, 2 = being serviced).
  bit m_en[N];
  bit m_pend[N];
  bit m_prev[N];
  bit m_gie, m_irq, m_busy, m_restore;
  int m_vec, m_phase;

  function automatic logic [31:0] pack(input bit a[N]);
    logic [31:0] v = '0;
    for (int i = 0; i < N; i++) v[i] = a[i];
    return v;
  endfunction

  task automatic model_step();
    bit en_next[N];
    bit any_en;
    int winner;
    bit new_gie;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_en[i] = 0; m_pend[i] = 0; m_prev[i] = 0;
      end
      m_gie = 0; m_irq = 0; m_busy = 0; m_restore = 0; m_vec = 0; m_phase = 0;
      return;
    end
    any_en = 0;
    for (int i = 0; i < N; i++) begin
      en_next[i] = pie_wr ? pie_wdata[i] : m_en[i];
      any_en |= en_next[i];
    end
    winner = -1;
    for (int i = 0; i < N && winner < 0; i++)
      if (m_pend[i] && m_en[i]) winner = i;

    new_gie = m_gie;
    if (gie_clr) new_gie = 0;
    else if (gie_set && m_phase != 2 && any_en) new_gie = 1;
    if (!any_en) new_gie = 0;

    if (m_phase == 0) begin
      if (m_gie && winner >= 0) begin m_phase = 1; m_irq = 1; end
    end else if (m_phase == 1) begin
      if (ack && winner >= 0) begin
        m_vec = winner; m_pend[winner] = 0; m_restore = !gie_clr;
        new_gie = 0; m_busy = 1; m_irq = 0; m_phase = 2;
      end else if (!m_gie || winner < 0) begin
        m_irq = 0; m_phase = 0;
      end
    end else begin
      if (eoi) begin
        new_gie = m_restore && !gie_clr && any_en;
        m_busy = 0; m_phase = 0;
      end
      if (gie_clr) m_restore = 0;
    end

    // New events are applied after the ack clear so they win on the same bit.
    for (int i = 0; i < N; i++) begin
      if (irq_in[i] && (!EM[i] || !m_prev[i])) m_pend[i] = 1;
      m_prev[i] = irq_in[i];
      m_en[i]   = en_next[i];
    end
    m_gie = new_gie;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("pie",        pie,        pack(m_en));
    check("gie",        gie,        m_gie);
    check("pending",    pending,    pack(m_pend));
    check("irq",        irq,        m_irq);
    check("in_service", in_service, m_busy);
    check("vector",     vector,     m_vec);
  endtask

  task automatic quiet();
    pie_wr = 0; gie_set = 0; gie_clr = 0; ack = 0; eoi = 0;
  endtask

  task automatic do_reset();
    quiet(); irq_in = '0; rst_n = 0; tick(); rst_n = 1;
  endtask

  task automatic enable_all();
    pie_wr = 1; pie_wdata = 8'hFF; gie_set = 1; tick(); quiet();
  endtask

  initial begin
    quiet(); irq_in = '0; pie_wdata = '0; rst_n = 0;
    tick(); tick();
    check("rst_pending", pending, 0);
    check("rst_irq", irq, 0);
    rst_n = 1;

    // GIE depends on a non-empty enable mask
    gie_set = 1; tick(); quiet();
    check("gie_no_pie", gie, 0);
    pie_wr = 1; pie_wdata = 8'h10; gie_set = 1; tick(); quiet();
    check("gie_with_pie", gie, 1);
    pie_wr = 1; pie_wdata = 8'h00; tick(); quiet();
    check("gie_pie_zero", gie, 0);

    // Simultaneous edges on 5 and 2, serviced in priority order
    do_reset(); enable_all();
    irq_in = 8'h24; tick();
    check("pend_24", pending, 8'h24);
    tick();
    check("irq_up", irq, 1);
    ack = 1; tick(); ack = 0;
    check("vec_2", vector, 2);
    check("pend_20", pending, 8'h20);
    check("gie_svc", gie, 0);
    eoi = 1; tick(); eoi = 0;
    check("gie_restored", gie, 1);
    tick();
    check("irq_again", irq, 1);
    ack = 1; tick(); ack = 0;
    check("vec_5", vector, 5);
    eoi = 1; tick(); eoi = 0;

    // Edge channel held high is captured exactly once
    do_reset(); enable_all();
    irq_in = 8'h08; tick(); tick();
    ack = 1; tick(); ack = 0;
    check("vec_3", vector, 3);
    eoi = 1; tick(); eoi = 0;
    repeat (6) tick();
    check("edge_once_pend", pending, 0);
    check("edge_once_irq", irq, 0);

    // Level channel keeps re-requesting while held
    irq_in = 8'h10; tick(); tick();
    ack = 1; tick(); ack = 0;
    check("vec_4", vector, 4);
    check("level_repend", pending[4], 1);
    eoi = 1; tick(); eoi = 0;
    tick();
    check("level_irq_again", irq, 1);
    irq_in = 0;

    // Withdrawal by gie_clr before ack; ack in IDLE ignored
    do_reset(); enable_all();
    irq_in = 8'h02; tick(); tick();
    check("irq_ch1", irq, 1);
    gie_clr = 1; tick(); gie_clr = 0;
    tick();
    check("withdrawn_irq", irq, 0);
    check("withdrawn_pend1", pending[1], 1);
    ack = 1; tick(); ack = 0;
    check("idle_ack_svc", in_service, 0);
    check("idle_ack_irq", irq, 0);

    // gie_clr during service blocks the restore; new edge in ack cycle wins
    do_reset(); enable_all();
    irq_in = 8'h01; tick(); irq_in = 0; tick();
    irq_in = 8'h01; ack = 1; tick(); ack = 0;
    check("set_wins_clr", pending[0], 1);
    gie_clr = 1; tick(); gie_clr = 0;
    eoi = 1; tick(); eoi = 0;
    check("gie_stays_0", gie, 0);
    irq_in = 0;

    // Reset in the middle of a service
    do_reset(); enable_all();
    irq_in = 8'h40; tick(); tick();
    ack = 1; tick(); ack = 0;
    check("svc_before_rst", in_service, 1);
    rst_n = 0; tick(); rst_n = 1;
    check("mid_rst_irq", irq, 0);
    check("mid_rst_svc", in_service, 0);
    check("mid_rst_gie", gie, 0);
    check("mid_rst_pend", pending, 0);
    check("mid_rst_pie", pie, 0);
    irq_in = 0;

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      irq_in    ^= 8'($urandom & $urandom & $urandom);
      pie_wr    = ($urandom_range(0, 19) == 0);
      pie_wdata = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      gie_set   = ($urandom_range(0, 2) == 0);
      gie_clr   = ($urandom_range(0, 15) == 0);
      ack       = ($urandom_range(0, 2) == 0);
      eoi       = ($urandom_range(0, 3) == 0);
      rst_n     = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1; quiet();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
